udp_echo_responder: RTL

Application-side UDP loopback engine between the UDP/IP/MAC stack's receive and transmit application ports. It captures one received UDP payload into an internal byte buffer, requests a transmit slot from the stack, and streams the same bytes back as the payload of an outgoing UDP datagram. The transmit-side ports map one-to-one onto the stack's `app_data_*` / `udp_send_ack` interface, and the receive-side ports onto `udp_rec_*`.

---
 rtl/udp_echo_responder_if.sv | 25 ++
 rtl/udp_echo_responder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/udp_echo_responder_if.sv
// Application-side port bundle between the UDP echo engine and the UDP/IP/MAC stack.
// The master modport is the stack side; the slave modport is the echo engine.
interface udp_echo_responder_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] rx_length;
  logic        link_ready;
  logic        tx_request;
  logic        tx_ack;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [15:0] tx_length;
  logic        busy;
  logic [15:0] drop_cnt;

  modport master (
    output rx_valid, rx_data, rx_length, link_ready, tx_ack,
    input  tx_request, tx_valid, tx_data, tx_length, busy, drop_cnt
  );

  modport slave (
    input  rx_valid, rx_data, rx_length, link_ready, tx_ack,
    output tx_request, tx_valid, tx_data, tx_length, busy, drop_cnt
  );
endinterface

// File: rtl/udp_echo_responder.sv
// UDP loopback engine: buffers one received payload, requests a send slot and streams
// the same bytes back; packets arriving while an echo is pending are dropped and counted.
module udp_echo_responder #(
  parameter int MAX_LEN     = 1472,
  parameter int ADDR_W      = 11,
  parameter int ACK_TIMEOUT = 125_000,
  parameter int GAP_CYCLES  = 12
) (
  input  logic rgmii_clk,
  input  logic rstn,
  udp_echo_responder_if.slave app
);
  // One extra bit so the byte count can reach MAX_LEN even when MAX_LEN == 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam int REQ_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(ACK_TIMEOUT - 1);
  localparam logic [REQ_W-1:0] REQ_ONE  = REQ_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [2:0] {IDLE, RECV, REQ, SEND, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [REQ_W-1:0] req_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             dropping;
  logic             tx_request_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic [15:0]      tx_length_q;
  logic [15:0]      drop_cnt_q;
  logic [7:0]       mem [0:MAX_LEN-1];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              req_timeout;
  logic              drop_start;
  logic              drop_end;
  logic [16:0]       drop_sum;
  logic              rx_length_unused;

  assign rx_length_unused = ^app.rx_length;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    rd_en   = 1'b0;
    rd_addr = rd_cnt[ADDR_W-1:0];
    case (state)
      IDLE: wr_en = app.rx_valid && !dropping;
      RECV: begin
        if (app.rx_valid && (wr_cnt < MAX_CNT)) begin
          wr_en   = 1'b1;
          wr_addr = wr_cnt[ADDR_W-1:0];
        end
      end
      SEND:    rd_en = 1'b1;
      default: ;
    endcase
    req_timeout = (state == REQ) && !app.tx_ack && (req_cnt == REQ_LAST);
    drop_start  = !dropping && app.rx_valid &&
                  ((state == REQ) || (state == SEND) || (state == GAP));
    drop_end    = dropping && !app.rx_valid;
    // A timeout and a dropped-packet end can coincide, so the sum may step by two.
    drop_sum    = {1'b0, drop_cnt_q} + 17'(drop_end) + 17'(req_timeout);
  end

  always_ff @(posedge rgmii_clk) begin
    if (wr_en) mem[wr_addr] <= app.rx_data;
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn)      tx_data_q <= '0;
    else if (rd_en) tx_data_q <= mem[rd_addr];
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      req_cnt      <= '0;
      gap_cnt      <= '0;
      dropping     <= 1'b0;
      tx_request_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_length_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      tx_valid_q   <= rd_en;
      tx_request_q <= 1'b0;
      drop_cnt_q   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (drop_start)    dropping <= 1'b1;
      else if (drop_end) dropping <= 1'b0;
      case (state)
        IDLE: begin
          if (app.rx_valid && !dropping) begin
            wr_cnt <= CNT_ONE;
            state  <= RECV;
          end
        end
        RECV: begin
          if (app.rx_valid) begin
            if (wr_cnt < MAX_CNT) wr_cnt <= wr_cnt + CNT_ONE;
          end else begin
            tx_length_q <= 16'(wr_cnt);
            req_cnt     <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (app.tx_ack) begin
            rd_cnt <= '0;
            state  <= SEND;
          end else if (req_timeout) begin
            state <= IDLE;
          end else begin
            req_cnt      <= req_cnt + REQ_ONE;
            tx_request_q <= app.link_ready;
          end
        end
        SEND: begin
          rd_cnt <= rd_cnt + CNT_ONE;
          if (rd_cnt == tx_length_q[CNT_W-1:0] - CNT_ONE) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + GAP_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign app.tx_request = tx_request_q;
  assign app.tx_valid   = tx_valid_q;
  assign app.tx_data    = tx_data_q;
  assign app.tx_length  = tx_length_q;
  assign app.drop_cnt   = drop_cnt_q;
  assign app.busy       = (state != IDLE);
endmodule
